loop_counter2d: RTL and testbench

- Two-level loop index generator for matrix traversal in the pageRank datapath, such as walking rank vector and adjacency rows.
- Accepts run-time outer and inner bounds on a start pulse.
- Emits an (i, j) index stream over a valid/ready handshake, with end-of-row and end-of-loop flags and a done pulse.
- Generalises the plain enable/clear counter to two dimensions, run-time limits, selectable loop order and back-pressure.

---
 rtl/loop_pkg.sv | 13 +
 rtl/loop_counter2d_idx_counter.sv | 26 ++
 rtl/loop_counter2d.sv | 92 +++++++++
 tb/tb_loop_counter2d.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_pkg.sv
// Shared types for the two-level loop index generator.
package loop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } loop_state_t;

    localparam int MODE_ROW_MAJOR = 0;
    localparam int MODE_COL_MAJOR = 1;

endpackage

// File: rtl/loop_counter2d_idx_counter.sv
// Single-dimension index register: counts 0..bound-1 on en, wraps back to 0.
module idx_counter #(
    parameter int NBITS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [NBITS-1:0] bound,
    output logic [NBITS-1:0] idx,
    output logic             wrap
);

    // One extra bit so a bound of 2^NBITS-1 compares without overflow.
    assign wrap = (({1'b0, idx} + {{NBITS{1'b0}}, 1'b1}) == {1'b0, bound});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idx <= '0;
        else if (clear)
            idx <= '0;
        else if (en)
            idx <= wrap ? '0 : idx + NBITS'(1);
    end

endmodule

// File: rtl/loop_counter2d.sv
// Two-level (i, j) index stream generator with valid/ready output.
// Optional macro LOOP2D_ABORT_EN adds an abort input that ends a run early.
module loop_counter2d
    import loop_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] i_bound,
    input  logic [NBITS-1:0] j_bound,
`ifdef LOOP2D_ABORT_EN
    input  logic             abort,
`endif
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_i,
    output logic [NBITS-1:0] out_j,
    output logic             out_last_inner,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    loop_state_t      state;
    logic [NBITS-1:0] i_bnd, j_bnd;
    logic [NBITS-1:0] in_bound, out_bound, in_idx, out_idx;
    logic             kick, stop, xfer, in_wrap, out_wrap;

`ifdef LOOP2D_ABORT_EN
    assign stop = (state == RUN) && abort;
`else
    assign stop = 1'b0;
`endif

    assign kick = (state == IDLE) && start;
    // An aborted cycle never counts as a transfer.
    assign xfer = out_val && out_rdy && !stop;

    assign in_bound  = (MODE == MODE_COL_MAJOR) ? i_bnd : j_bnd;
    assign out_bound = (MODE == MODE_COL_MAJOR) ? j_bnd : i_bnd;

    idx_counter #(.NBITS(NBITS)) u_inner (
        .clk   (clk),
        .reset (reset),
        .clear (kick),
        .en    (xfer),
        .bound (in_bound),
        .idx   (in_idx),
        .wrap  (in_wrap)
    );

    idx_counter #(.NBITS(NBITS)) u_outer (
        .clk   (clk),
        .reset (reset),
        .clear (kick),
        .en    (xfer && in_wrap),
        .bound (out_bound),
        .idx   (out_idx),
        .wrap  (out_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            i_bnd <= '0;
            j_bnd <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i_bnd <= i_bound;
                    j_bnd <= j_bound;
                    state <= (i_bound == '0 || j_bound == '0) ? DONE : RUN;
                end
                RUN: if (stop || (xfer && in_wrap && out_wrap))
                    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign out_val        = (state == RUN);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign out_last_inner = out_val && in_wrap;
    assign out_last       = out_val && in_wrap && out_wrap;
    assign out_i          = (MODE == MODE_COL_MAJOR) ? in_idx  : out_idx;
    assign out_j          = (MODE == MODE_COL_MAJOR) ? out_idx : in_idx;

endmodule

// File: tb/tb_loop_counter2d.sv
// Bench for loop_counter2d: one row-major and one column-major instance share stimulus.
module tb_loop_counter2d;

    localparam int NB = 8;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_rdy = 1'b0, abort = 1'b0;
    logic [NB-1:0] i_bound = '0, j_bound = '0;
    logic          val[2], li[2], la[2], busy[2], done[2];
    logic [NB-1:0] oi[2], oj[2];

    int passed = 0, total = 0;
    int cyc = 0;
    int rec0[$], rec1[$];

    int m_st[2] = '{0, 0};
    int m_k[2]  = '{0, 0};
    int m_ib = 0, m_jb = 0;
    logic          hold[2] = '{1'b0, 1'b0};
    logic [NB-1:0] p_i[2], p_j[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        loop_counter2d #(.NBITS(NB), .MODE(g)) dut (
            .clk            (clk),
            .reset          (reset),
            .start          (start),
            .i_bound        (i_bound),
            .j_bound        (j_bound),
`ifdef LOOP2D_ABORT_EN
            .abort          (abort),
`endif
            .out_val        (val[g]),
            .out_rdy        (out_rdy),
            .out_i          (oi[g]),
            .out_j          (oj[g]),
            .out_last_inner (li[g]),
            .out_last       (la[g]),
            .busy           (busy[g]),
            .done           (done[g])
        );
    end

    task automatic chk(input string nm, input int d, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    endtask

    // Reference: state 0 idle, 1 running (k-th pair on offer), 2 done.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_st[d] <= 0;
                m_k[d]  <= 0;
            end
        end else begin
            if (m_st[0] == 0 && start) begin
                m_ib <= i_bound;
                m_jb <= j_bound;
            end
            for (int d = 0; d < 2; d++) begin
                case (m_st[d])
                    0: if (start) begin
                        m_k[d]  <= 0;
                        m_st[d] <= (i_bound == 0 || j_bound == 0) ? 2 : 1;
                    end
                    1: if (abort) m_st[d] <= 2;
                       else if (out_rdy) begin
                           if (m_k[d] == m_ib * m_jb - 1) m_st[d] <= 2;
                           else m_k[d] <= m_k[d] + 1;
                       end
                    default: m_st[d] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int k, ei, ej;
            if (!reset) begin
                chk("rst_zero", d, {val[d], busy[d], done[d], li[d], la[d], (|oi[d]), (|oj[d])}, 0);
            end else begin
                chk("out_val", d, val[d], m_st[d] == 1);
                chk("busy", d, busy[d], m_st[d] != 0);
                chk("done", d, done[d], m_st[d] == 2);
                if (m_st[d] == 1) begin
                    k = m_k[d];
                    if (d == 0) begin ei = k / m_jb; ej = k % m_jb; end
                    else        begin ei = k % m_ib; ej = k / m_ib; end
                    chk("out_i", d, oi[d], ei);
                    chk("out_j", d, oj[d], ej);
                    chk("last_inner", d, li[d], (d == 0) ? (ej == m_jb - 1) : (ei == m_ib - 1));
                    chk("last", d, la[d], k == m_ib * m_jb - 1);
                end
                if (hold[d] && val[d]) begin
                    chk("hold_i", d, oi[d], p_i[d]);
                    chk("hold_j", d, oj[d], p_j[d]);
                end
            end
            hold[d] <= reset && val[d] && !out_rdy && !abort;
            p_i[d]  <= oi[d];
            p_j[d]  <= oj[d];
        end
    end

    always @(negedge clk) begin
        if (reset && out_rdy && !abort) begin
            if (val[0]) begin rec0.push_back(oi[0]); rec0.push_back(oj[0]); end
            if (val[1]) begin rec1.push_back(oi[1]); rec1.push_back(oj[1]); end
        end
    end

    // Starts a run, waits for done, returns start-to-done cycle count inclusive.
    task automatic run(input int ib, input int jb, input bit bp, output int cycles);
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int t0, n;
        rec0.delete();
        rec1.delete();
        i_bound = NB'(ib);
        j_bound = NB'(jb);
        start   = 1'b1;
        out_rdy = 1'b1;
        t0      = cyc;
        n       = 0;
        cycles  = -1;
        while (n < 2000) begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (bp) out_rdy = pat[n % 4];
            if (done[0]) begin
                cycles = cyc - t0 + 1;
                break;
            end
        end
        chk("done_seen", 0, cycles > 0, 1);
        out_rdy = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_ignored", 0, busy[0], 0);
    endtask

    initial begin
        int cycles;
        int e0[12] = '{0,0, 0,1, 0,2, 1,0, 1,1, 1,2};
        int e1[12] = '{0,0, 1,0, 0,1, 1,1, 0,2, 1,2};
        int ebp[8] = '{0,0, 0,1, 0,2, 0,3};

        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_val", 0, val[0], 0);
        chk("reset_busy", 1, busy[1], 0);
        reset = 1'b1;
        @(posedge clk); #1;

        run(2, 3, 0, cycles);
        chk("cycles_2x3", 0, cycles, 8);
        chk("count_2x3_row", 0, rec0.size(), 12);
        chk("count_2x3_col", 1, rec1.size(), 12);
        for (int n = 0; n < 12; n++) begin
            if (n < rec0.size()) chk("order_row", 0, rec0[n], e0[n]);
            if (n < rec1.size()) chk("order_col", 1, rec1[n], e1[n]);
        end

        run(0, 5, 0, cycles);
        chk("cycles_zero_bound", 0, cycles, 2);
        chk("count_zero_bound", 0, rec0.size(), 0);

        run(1, 4, 1, cycles);
        chk("cycles_backpressure", 0, cycles, 10);
        chk("count_backpressure", 0, rec0.size(), 8);
        for (int n = 0; n < 8; n++)
            if (n < rec0.size()) chk("order_backpressure", 0, rec0[n], ebp[n]);

        run(1, 255, 0, cycles);
        chk("cycles_max_bound", 0, cycles, 257);
        chk("count_max_bound", 1, rec1.size(), 510);
        if (rec0.size() == 510) chk("last_j_max_bound", 0, rec0[509], 254);

        // Reset in the middle of a 3x3 run, at pair (1,1).
        i_bound = 3; j_bound = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_i", 0, oi[0], 1);
        chk("pre_reset_j", 0, oj[0], 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 0, {val[0], busy[0], oi[0], oj[0]}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_after_reset", 0, done[0], 0);
        end
        run(3, 3, 0, cycles);
        chk("cycles_restart", 0, cycles, 11);
        if (rec0.size() >= 2) begin
            chk("restart_i0", 0, rec0[0], 0);
            chk("restart_j0", 0, rec0[1], 0);
        end

`ifdef LOOP2D_ABORT_EN
        rec0.delete();
        i_bound = 2; j_bound = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_at_j", 0, oj[0], 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_done", 0, done[0], 1);
        chk("abort_val", 0, val[0], 0);
        chk("abort_count", 0, rec0.size(), 4);
        @(posedge clk); #1;
        chk("abort_idle", 0, busy[0], 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
